// File: rtl/dcp_stream_pkg.sv
// Shared stream definitions for the dehaze pipeline: FSM states, beat tag layout,
// default frame geometry and a constant clog2 helper.
package dcp_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } dcp_state_t;

  // Tag bits sit directly above TDATA in each buffered entry: {eof, eol, sof, data}
  localparam int unsigned TAG_SOF = 0;
  localparam int unsigned TAG_EOL = 1;
  localparam int unsigned TAG_EOF = 2;
  localparam int unsigned TAG_W   = 3;

  localparam int unsigned DEF_IMG_WIDTH  = 512;
  localparam int unsigned DEF_IMG_HEIGHT = 512;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO: head entry is visible on rd_data
// whenever empty is low; a write into an empty FIFO appears one cycle later.
module axis_sync_fifo
  import dcp_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 35
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A write while full is only allowed when the head leaves in the same cycle
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/axis_frame_packer.sv
// Re-frames the free-running dehaze pixel stream into AXI4-Stream video frames.
// Build option DCP_LINE_TLAST_EN: TLAST marks every line end instead of frame end only.
module axis_frame_packer
  import dcp_stream_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic                        enable,
  input  logic [DATA_W-1:0]           S_AXIS_TDATA,
  input  logic                        S_AXIS_TVALID,
  output logic                        S_AXIS_TREADY,
  output logic [DATA_W-1:0]           M_AXIS_TDATA,
  output logic                        M_AXIS_TVALID,
  output logic                        M_AXIS_TLAST,
  output logic                        M_AXIS_TUSER,
  input  logic                        M_AXIS_TREADY,
  output logic                        frame_done,
  output logic                        overflow,
  output logic                        busy,
  output logic [clog2(FIFO_DEPTH):0]  fill_level
);

  localparam int unsigned CW = clog2(IMG_WIDTH);
  localparam int unsigned RW = (IMG_HEIGHT > 1) ? clog2(IMG_HEIGHT) : 1;
  localparam int unsigned EW = DATA_W + TAG_W;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  dcp_state_t state, state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          sof, eol, eof;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  assign sof = (col == '0) && (row == '0);
  assign eol = (col == COL_LAST);
  assign eof = eol && (row == ROW_LAST);

  always_comb begin
    wr_entry                 = '0;
    wr_entry[DATA_W-1:0]     = S_AXIS_TDATA;
    wr_entry[DATA_W+TAG_SOF] = sof;
    wr_entry[DATA_W+TAG_EOL] = eol;
    wr_entry[DATA_W+TAG_EOF] = eof;
  end

  assign pop = ~fifo_empty & M_AXIS_TREADY;

  axis_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .wr_en   (accept),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fill_level)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (accept && eof && !enable) state_nxt = ST_FLUSH;
      ST_FLUSH:  if (fifo_empty) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    accept = S_AXIS_TVALID & (((state == ST_IDLE) & enable) | (state == ST_ACTIVE));
    busy   = (state != ST_IDLE);
  end

  // Counters advance even when the FIFO drops the beat so framing stays pixel-aligned
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (eol) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (accept && fifo_full && !pop) overflow <= 1'b1;
      frame_done <= pop & head[DATA_W+TAG_EOF];
    end
  end

  assign S_AXIS_TREADY = ~fifo_full;
  assign M_AXIS_TVALID = ~fifo_empty;
  assign M_AXIS_TDATA  = fifo_empty ? '0 : head[DATA_W-1:0];
  assign M_AXIS_TUSER  = ~fifo_empty & head[DATA_W+TAG_SOF];
`ifdef DCP_LINE_TLAST_EN
  assign M_AXIS_TLAST  = ~fifo_empty & head[DATA_W+TAG_EOL];
`else
  assign M_AXIS_TLAST  = ~fifo_empty & head[DATA_W+TAG_EOF];
  logic unused_eol_tag;
  assign unused_eol_tag = head[DATA_W+TAG_EOL];
`endif

endmodule

// File: tb/tb_axis_frame_packer.sv
// Scoreboard bench for axis_frame_packer (4x2 frames, 4-entry FIFO); follows DCP_LINE_TLAST_EN.
module tb_axis_frame_packer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int D  = 4;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] S_AXIS_TDATA = '0;
  logic          S_AXIS_TVALID = 1'b0;
  logic          S_AXIS_TREADY;
  logic [DW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TUSER;
  logic          M_AXIS_TREADY = 1'b0;
  logic          frame_done;
  logic          overflow;
  logic          busy;
  logic [2:0]    fill_level;

  always #5 ACLK = ~ACLK;

  axis_frame_packer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .FIFO_DEPTH (D),
    .DATA_W     (DW)
  ) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .enable        (enable),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TUSER  (M_AXIS_TUSER),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .frame_done    (frame_done),
    .overflow      (overflow),
    .busy          (busy),
    .fill_level    (fill_level)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          tuser;
    logic          tlast;
    logic          eof;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   fd_seen = 0;
  bit   fd_exp = 1'b0;
  bit   mon_en = 1'b0;
  int   mc = 0;
  int   mr = 0;

  // Output monitor: pops the scoreboard on each handshake and checks frame_done every cycle
  always @(negedge ACLK) begin
    exp_t e;
    if (mon_en) begin
      total++;
      if (frame_done !== fd_exp) begin
        bad++;
        $display("FAIL frame_done: got %b want %b", frame_done, fd_exp);
      end
      if (frame_done === 1'b1) fd_seen++;
      fd_exp = 1'b0;
      if (M_AXIS_TVALID === 1'b1 && M_AXIS_TREADY === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got data=%h want no beat", M_AXIS_TDATA);
        end else begin
          e = q.pop_front();
          if ({M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST} !== {e.data, e.tuser, e.tlast}) begin
            bad++;
            $display("FAIL out_beat: got data=%h user=%b last=%b want data=%h user=%b last=%b",
                     M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST, e.data, e.tuser, e.tlast);
          end
          fd_exp = e.eof;
        end
      end
    end
  end

  task automatic model_beat(input logic [DW-1:0] d, input bit keep);
    exp_t e;
    bit   eol;
    eol     = (mc == W - 1);
    e.data  = d;
    e.tuser = (mc == 0 && mr == 0);
    e.eof   = eol && (mr == H - 1);
`ifdef DCP_LINE_TLAST_EN
    e.tlast = eol;
`else
    e.tlast = e.eof;
`endif
    if (keep) q.push_back(e);
    if (eol) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  // Called at posedge+1; presents one beat for one cycle and returns at the next posedge+1
  task automatic drive_beat(input logic [DW-1:0] d, input bit acc, input bit keep);
    S_AXIS_TDATA  = d;
    S_AXIS_TVALID = 1'b1;
    if (acc) model_beat(d, keep);
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_in();
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA  = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(posedge ACLK);
      #1;
    end
    repeat (3) @(posedge ACLK);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge ACLK);
    mon_en  = 1'b0;
    ARESETn = 1'b0;
    q.delete();
    fd_exp  = 1'b0;
    mc = 0;
    mr = 0;
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    total++;
    if ({M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST, frame_done, overflow, busy, fill_level} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b data=%h user=%b last=%b fd=%b ovf=%b busy=%b fill=%0d want all 0",
               M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST, frame_done, overflow, busy, fill_level);
    end
    ARESETn = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic test_frame();
    int fd0;
    fd0 = fd_seen;
    enable        = 1'b1;
    M_AXIS_TREADY = 1'b1;
    S_AXIS_TDATA  = 32'h01;
    S_AXIS_TVALID = 1'b1;
    model_beat(32'h01, 1'b1);
    #2;
    total++;
    if (M_AXIS_TVALID !== 1'b0) begin
      bad++;
      $display("FAIL no_bypass: got valid=%b want 0", M_AXIS_TVALID);
    end
    @(posedge ACLK);
    #1;
    total++;
    if ({M_AXIS_TVALID, M_AXIS_TDATA} !== {1'b1, 32'h01}) begin
      bad++;
      $display("FAIL latency1: got valid=%b data=%h want 1/01", M_AXIS_TVALID, M_AXIS_TDATA);
    end
    for (int d = 2; d <= 8; d++) drive_beat(DW'(d), 1'b1, 1'b1);
    idle_in();
    drain();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL frame_drain: got %0d pending want 0", q.size());
    end
    total++;
    if (fd_seen - fd0 != 1) begin
      bad++;
      $display("FAIL frame_done_count: got %0d want 1", fd_seen - fd0);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL frame_overflow: got %b want 0", overflow);
    end
  endtask

  task automatic test_overflow();
    int fd0;
    fd0 = fd_seen;
    M_AXIS_TREADY = 1'b0;
    for (int d = 1; d <= 6; d++) drive_beat(DW'(d), 1'b1, d <= 4);
    idle_in();
    total++;
    if ({fill_level, S_AXIS_TREADY, overflow} !== {3'd4, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL full_state: got fill=%0d tready=%b ovf=%b want 4/0/1", fill_level, S_AXIS_TREADY, overflow);
    end
    repeat (3) @(posedge ACLK);
    #1;
    total++;
    if ({M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TUSER} !== {1'b1, 32'h01, 1'b1}) begin
      bad++;
      $display("FAIL stall_hold: got valid=%b data=%h user=%b want 1/01/1", M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TUSER);
    end
    M_AXIS_TREADY = 1'b1;
    drain();
    total++;
    if (q.size() != 0 || fd_seen != fd0) begin
      bad++;
      $display("FAIL partial_frame: got pending=%0d fd=%0d want 0/0", q.size(), fd_seen - fd0);
    end
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky: got %b want 1", overflow);
    end
    drive_beat(32'h07, 1'b1, 1'b1);
    drive_beat(32'h08, 1'b1, 1'b1);
    idle_in();
    drain();
    total++;
    if (q.size() != 0 || fd_seen - fd0 != 1) begin
      bad++;
      $display("FAIL realign: got pending=%0d fd=%0d want 0/1", q.size(), fd_seen - fd0);
    end
  endtask

  task automatic test_enable();
    int fd0;
    pulse_reset();
    fd0 = fd_seen;
    M_AXIS_TREADY = 1'b1;
    enable = 1'b0;
    for (int d = 17; d <= 19; d++) drive_beat(DW'(d), 1'b0, 1'b0);
    idle_in();
    @(posedge ACLK);
    #1;
    total++;
    if ({fill_level, M_AXIS_TVALID, busy} !== '0) begin
      bad++;
      $display("FAIL disabled_discard: got fill=%0d valid=%b busy=%b want 0/0/0", fill_level, M_AXIS_TVALID, busy);
    end
    enable = 1'b1;
    for (int d = 1; d <= 3; d++) drive_beat(DW'(d), 1'b1, 1'b1);
    enable = 1'b0;
    for (int d = 4; d <= 8; d++) drive_beat(DW'(d), 1'b1, 1'b1);
    idle_in();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL flush_busy: got %b want 1", busy);
    end
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b0) break;
      @(posedge ACLK);
      #1;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_to_idle: got busy=%b want 0", busy);
    end
    drain();
    total++;
    if (q.size() != 0 || fd_seen - fd0 != 1) begin
      bad++;
      $display("FAIL enable_drop_frame: got pending=%0d fd=%0d want 0/1", q.size(), fd_seen - fd0);
    end
    drive_beat(32'h09, 1'b0, 1'b0);
    idle_in();
    @(posedge ACLK);
    #1;
    total++;
    if ({fill_level, M_AXIS_TVALID, busy} !== '0) begin
      bad++;
      $display("FAIL post_flush_ignore: got fill=%0d valid=%b busy=%b want 0/0/0", fill_level, M_AXIS_TVALID, busy);
    end
  endtask

  task automatic test_full_pushpop();
    int fd0;
    fd0 = fd_seen;
    enable = 1'b1;
    M_AXIS_TREADY = 1'b0;
    for (int d = 1; d <= 4; d++) drive_beat(DW'(32'h30 + d), 1'b1, 1'b1);
    total++;
    if (fill_level !== 3'd4) begin
      bad++;
      $display("FAIL fill_to_full: got %0d want 4", fill_level);
    end
    M_AXIS_TREADY = 1'b1;
    drive_beat(32'h35, 1'b1, 1'b1);
    M_AXIS_TREADY = 1'b0;
    idle_in();
    total++;
    if ({fill_level, overflow, M_AXIS_TDATA} !== {3'd4, 1'b0, 32'h32}) begin
      bad++;
      $display("FAIL full_pushpop: got fill=%0d ovf=%b head=%h want 4/0/32", fill_level, overflow, M_AXIS_TDATA);
    end
    M_AXIS_TREADY = 1'b1;
    for (int d = 6; d <= 8; d++) drive_beat(DW'(32'h30 + d), 1'b1, 1'b1);
    idle_in();
    drain();
    total++;
    if (q.size() != 0 || fd_seen - fd0 != 1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL pushpop_frame: got pending=%0d fd=%0d ovf=%b want 0/1/0", q.size(), fd_seen - fd0, overflow);
    end
  endtask

  task automatic test_reset_midframe();
    enable = 1'b1;
    M_AXIS_TREADY = 1'b0;
    for (int d = 1; d <= 5; d++) drive_beat(DW'(32'h20 + d), 1'b1, d <= 4);
    idle_in();
    total++;
    if ({M_AXIS_TVALID, overflow, busy} !== 3'b111) begin
      bad++;
      $display("FAIL pre_reset: got valid=%b ovf=%b busy=%b want 1/1/1", M_AXIS_TVALID, overflow, busy);
    end
    @(negedge ACLK);
    #2;
    mon_en  = 1'b0;
    ARESETn = 1'b0;
    #1;
    total++;
    if ({M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST, frame_done, overflow, busy, fill_level} !== '0) begin
      bad++;
      $display("FAIL async_reset: got valid=%b data=%h user=%b last=%b fd=%b ovf=%b busy=%b fill=%0d want all 0",
               M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST, frame_done, overflow, busy, fill_level);
    end
    q.delete();
    fd_exp = 1'b0;
    mc = 0;
    mr = 0;
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    mon_en  = 1'b1;
    M_AXIS_TREADY = 1'b1;
    drive_beat(32'hA0, 1'b1, 1'b1);
    idle_in();
    total++;
    if ({M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TUSER} !== {1'b1, 32'hA0, 1'b1}) begin
      bad++;
      $display("FAIL restart_sof: got valid=%b data=%h user=%b want 1/a0/1", M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TUSER);
    end
    drain();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL restart_drain: got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    @(posedge ACLK);
    #1;
    test_frame();
    test_overflow();
    test_enable();
    test_full_pushpop();
    test_reset_midframe();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
